serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial W-bit subtractor: diff = a - b - bin, one bit per clock through a single full-subtractor cell.
//   Counterpart of the combinational full adder. Borrow ripples through a borrow flip-flop, not a carry chain.
//   Start/busy/done handshake; sits beside the adder blocks as the area-minimal subtract path.
// PARAMETERS
//   W    8    operand/result width in bits (W >= 2)
// PORTS
//   clk    in   1   single clock, rising edge
//   rst    in   1   asynchronous, active-high reset
//   start  in   1   request; sampled only in IDLE
//   a      in   W   minuend, captured on accepted start
//   b      in   W   subtrahend, captured on accepted start
//   bin    in   1   borrow-in, captured on accepted start
//   busy   out  1   high in SHIFT and DONE
//   done   out  1   one-cycle pulse; diff/bout valid from this cycle
//   diff   out  W   result; held until next accepted start
//   bout   out  1   borrow-out (1 = unsigned a < b + bin)
//   ovf    out  1   signed overflow (only with SERSUB_OVF_EN)
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; shift regs, count, borrow=0.
//   FSM: IDLE --start--> SHIFT --(count==W-1)--> DONE --(always)--> IDLE.
//   IDLE: start=1 at edge loads a_sr<=a, b_sr<=b, br<=bin, count<=0; start=0 holds outputs.
//   SHIFT, per cycle, LSB first: d = a_sr[0]^b_sr[0]^br;
//     br <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0]^b_sr[0]) & br);
//     diff_sr <= {d, diff_sr[W-1:1]}; a_sr, b_sr shift right; count++.
//   Exactly W SHIFT cycles. On the last, diff<=diff_sr result, bout<=final br.
//   DONE: done=1 for exactly one cycle; busy=1; return to IDLE next edge.
//   Latency: start accepted at edge 0 -> done high during cycle W+1 (W=8: 9 cycles); throughput 1 op / W+2 cycles.
//   start while busy (SHIFT or DONE): ignored, no effect on the result in flight; a/b/bin may change freely after accept.
//   start held high continuously: next op accepted on the first IDLE cycle after DONE.
//   diff/bout do not change during SHIFT; they update only at the SHIFT->DONE edge.
//   Reset mid-operation: op abandoned, outputs zeroed, no done pulse.
//   Arithmetic is modulo 2^W; bout gives the unsigned borrow. No saturation.
// CONFIGURATION
//   SERSUB_OVF_EN defined: port ovf present. Capture sa=a[W-1], sb=b[W-1] at start.
//     At SHIFT->DONE: ovf <= (sa ^ sb) & (sa ^ d_msb). Held until next accepted start; reset 0.
//   Undefined: no ovf port, no sign registers; all other behaviour identical.
// STRUCTURE
//   Package sersub_pkg: state enum {IDLE, SHIFT, DONE} (2-bit encoding); function CNT_W(W) = $clog2(W).
//   Sub-module full_subtractor (a, b, bin -> d, bout), purely combinational, one instance.
//   Top level: FSM, count register, three W-bit shift registers, borrow FF, output registers.
// TESTING (W=8, unless noted)
//   full_subtractor standalone, all 8 {a,b,bin} combos -> d = a^b^bin, bout = (~a&b)|(~(a^b)&bin).
//   a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0; done exactly 9 cycles after start edge, 1 cycle wide.
//   a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
//   a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1 (SERSUB_OVF_EN); a=0x7F, b=0xFF -> diff=0x80, ovf=1.
//   start pulsed with a=0xAA, b=0x11 mid-SHIFT of 0x05-0x03 -> result still 0x02, one done only.
//   rst asserted in cycle 4 of SHIFT -> busy/done/diff/bout=0 immediately; next start gives a correct result.
//   Random: 1000 ops, W in {2,8,16} -> {bout,diff} == a - b - bin against the reference model.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and sizing helper for the serial subtractor
package sersub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sersub_state_e;

  function automatic int CNT_W(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done operand bus; ovf present only with SERSUB_OVF_EN
interface serial_subtractor_if #(
  parameter int W = 8
);

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERSUB_OVF_EN
  logic         ovf;
`endif

  modport master (
    output start, a, b, bin,
`ifdef SERSUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
`ifdef SERSUB_OVF_EN
    output ovf,
`endif
    output busy, done, diff, bout
  );

endinterface

// File: rtl/serial_subtractor_fs.sv
// rtl/serial_subtractor_fs.sv - combinational one-bit full subtractor cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first through one full_subtractor
// Optional signed overflow flag enabled by defining SERSUB_OVF_EN.
module serial_subtractor
  import sersub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_subtractor_if.slave bus
);

  localparam int             CW       = CNT_W(W);
  localparam logic [1:0]     ST_IDLE  = IDLE;
  localparam logic [1:0]     ST_SHIFT = SHIFT;
  localparam logic [1:0]     ST_DONE  = DONE;
  localparam logic [CW-1:0]  LAST     = CW'(W - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  a_sr_q, a_sr_d;
  logic [W-1:0]  b_sr_q, b_sr_d;
  logic [W-1:0]  diff_sr_q, diff_sr_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          br_q, br_d;
  logic          bout_q, bout_d;
  logic          fs_d, fs_bout;
`ifdef SERSUB_OVF_EN
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;
  logic          ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    diff_d    = diff_q;
    br_d      = br_q;
    bout_d    = bout_q;
`ifdef SERSUB_OVF_EN
    sa_d      = sa_q;
    sb_d      = sb_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          br_d    = bus.bin;
          count_d = '0;
          state_d = ST_SHIFT;
`ifdef SERSUB_OVF_EN
          sa_d    = bus.a[W-1];
          sb_d    = bus.b[W-1];
`endif
        end
      end
      ST_SHIFT: begin
        diff_sr_d = {fs_d, diff_sr_q[W-1:1]};
        a_sr_d    = {1'b0, a_sr_q[W-1:1]};
        b_sr_d    = {1'b0, b_sr_q[W-1:1]};
        br_d      = fs_bout;
        count_d   = count_q + 1'b1;
        // Visible result only moves on the final bit, so diff/bout stay stable mid-operation.
        if (count_q == LAST) begin
          state_d = ST_DONE;
          diff_d  = diff_sr_d;
          bout_d  = fs_bout;
`ifdef SERSUB_OVF_EN
          ovf_d   = (sa_q ^ sb_q) & (sa_q ^ fs_d);
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      diff_q    <= '0;
      br_q      <= 1'b0;
      bout_q    <= 1'b0;
`ifdef SERSUB_OVF_EN
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      diff_q    <= diff_d;
      br_q      <= br_d;
      bout_q    <= bout_d;
`ifdef SERSUB_OVF_EN
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERSUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at W = 2, 8, 16
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.W(2))  if2 ();
  serial_subtractor_if #(.W(8))  if8 ();
  serial_subtractor_if #(.W(16)) if16 ();

  serial_subtractor #(.W(2))  u2  (.clk(clk), .rst(rst), .bus(if2));
  serial_subtractor #(.W(8))  u8  (.clk(clk), .rst(rst), .bus(if8));
  serial_subtractor #(.W(16)) u16 (.clk(clk), .rst(rst), .bus(if16));

  logic fs_a, fs_b, fs_bin, fs_d, fs_bout;
  full_subtractor u_fs (.a(fs_a), .b(fs_b), .bin(fs_bin), .d(fs_d), .bout(fs_bout));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic a, b, bin, d, bout;
  } fs_vec_t;

  typedef struct {
    logic [7:0] a, b;
    logic       bin;
    logic [7:0] diff;
    logic       bout, ovf;
  } op_vec_t;

  fs_vec_t fs_tab[8];
  op_vec_t op_tab[8];

  // Unsigned reference: {borrow, W-bit difference} from plain integer subtraction.
  function automatic logic [16:0] ref_sub(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic bin);
    longint r, m, u;
    r = longint'(a) - longint'(b) - longint'(bin);
    m = longint'(1) << w;
    u = (r < 0) ? r + m : r;
    return {(r < 0), u[15:0]};
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      output logic [7:0] diff, output logic bout, output logic ovf,
                      output int lat, output logic held, output logic done_after);
    logic [7:0] prev;
    prev = if8.diff;
    diff = '0; bout = 1'b0; ovf = 1'b0; lat = -1; held = 1'b1;
    if8.a = a; if8.b = b; if8.bin = bin; if8.start = 1'b1;
    @(posedge clk);
    #1 if8.start = 1'b0;
    for (int c = 1; c <= 30 && lat < 0; c++) begin
      @(negedge clk);
      if (if8.done) begin
        lat  = c;
        diff = if8.diff;
        bout = if8.bout;
`ifdef SERSUB_OVF_EN
        ovf  = if8.ovf;
`endif
      end else if (if8.diff !== prev) held = 1'b0;
    end
    @(negedge clk);
    done_after = if8.done;
  endtask

  initial begin
    logic [7:0] r_diff;
    logic       r_bout, r_ovf, r_held, r_after;
    int         r_lat, ndone, t1, t2;
    logic [7:0] v1, v2, res;
    logic       got2, got8, got16, saw_done;
    logic [15:0] ra2, rb2, ra8, rb8, ra16, rb16;
    logic        rc2, rc8, rc16;

    fs_tab[0] = '{0,0,0, 0,0};  fs_tab[1] = '{0,0,1, 1,1};
    fs_tab[2] = '{0,1,0, 1,1};  fs_tab[3] = '{0,1,1, 0,1};
    fs_tab[4] = '{1,0,0, 1,0};  fs_tab[5] = '{1,0,1, 0,0};
    fs_tab[6] = '{1,1,0, 0,0};  fs_tab[7] = '{1,1,1, 1,1};

    op_tab[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    op_tab[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    op_tab[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    op_tab[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    op_tab[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    op_tab[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    op_tab[6] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
    op_tab[7] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};

    rst = 1'b1;
    if2.start = 0;  if2.a = '0;  if2.b = '0;  if2.bin = 0;
    if8.start = 0;  if8.a = '0;  if8.b = '0;  if8.bin = 0;
    if16.start = 0; if16.a = '0; if16.b = '0; if16.bin = 0;
    fs_a = 0; fs_b = 0; fs_bin = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(if8.busy), 0);
    chk("rst_done", 32'(if8.done), 0);
    chk("rst_diff", 32'(if8.diff), 0);
    chk("rst_bout", 32'(if8.bout), 0);
    chk("rst_diff16", 32'(if16.diff), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      fs_a = fs_tab[i].a; fs_b = fs_tab[i].b; fs_bin = fs_tab[i].bin;
      #1;
      chk($sformatf("fs_d[%0d]", i), 32'(fs_d), 32'(fs_tab[i].d));
      chk($sformatf("fs_bout[%0d]", i), 32'(fs_bout), 32'(fs_tab[i].bout));
    end
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run8(op_tab[i].a, op_tab[i].b, op_tab[i].bin, r_diff, r_bout, r_ovf, r_lat, r_held, r_after);
      chk($sformatf("tab_diff[%0d]", i), 32'(r_diff), 32'(op_tab[i].diff));
      chk($sformatf("tab_bout[%0d]", i), 32'(r_bout), 32'(op_tab[i].bout));
      chk($sformatf("tab_latency[%0d]", i), 32'(r_lat), 9);
      chk($sformatf("tab_diff_held[%0d]", i), 32'(r_held), 1);
      chk($sformatf("tab_done_width[%0d]", i), 32'(r_after), 0);
`ifdef SERSUB_OVF_EN
      chk($sformatf("tab_ovf[%0d]", i), 32'(r_ovf), 32'(op_tab[i].ovf));
`endif
    end

    // start pulsed mid-SHIFT must not disturb the op in flight
    if8.a = 8'h05; if8.b = 8'h03; if8.bin = 0; if8.start = 1;
    @(posedge clk);
    #1 if8.start = 0;
    ndone = 0; res = '0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (if8.done) begin ndone++; res = if8.diff; end
      if (c == 3) begin if8.a = 8'hAA; if8.b = 8'h11; if8.start = 1; end
      if (c == 4) if8.start = 0;
    end
    chk("busy_start_ndone", 32'(ndone), 1);
    chk("busy_start_diff", 32'(res), 32'h02);
    chk("busy_start_final", 32'(if8.diff), 32'h02);

    // start held high: back-to-back ops one IDLE cycle apart; operands changed after accept
    if8.a = 8'h05; if8.b = 8'h03; if8.bin = 0; if8.start = 1;
    @(posedge clk);
    #1 begin if8.a = 8'h10; if8.b = 8'h01; end
    t1 = -1; t2 = -1; v1 = '0; v2 = '0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (if8.done) begin
        if (t1 < 0) begin t1 = c; v1 = if8.diff; end
        else begin t2 = c; v2 = if8.diff; end
      end
      if (c == 11) if8.start = 0;
    end
    chk("held_t1", 32'(t1), 9);
    chk("held_v1", 32'(v1), 32'h02);
    chk("held_t2", 32'(t2), 19);
    chk("held_v2", 32'(v2), 32'h0F);

    // reset in cycle 4 of SHIFT clears outputs without a clock edge
    if8.a = 8'hFF; if8.b = 8'h00; if8.bin = 0; if8.start = 1;
    @(posedge clk);
    #1 if8.start = 0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(if8.busy), 0);
    chk("midrst_done", 32'(if8.done), 0);
    chk("midrst_diff", 32'(if8.diff), 0);
    chk("midrst_bout", 32'(if8.bout), 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (if8.done || if8.busy) saw_done = 1;
    end
    chk("midrst_no_done", 32'(saw_done), 0);
    run8(8'h05, 8'h03, 1'b0, r_diff, r_bout, r_ovf, r_lat, r_held, r_after);
    chk("post_rst_diff", 32'(r_diff), 32'h02);
    chk("post_rst_bout", 32'(r_bout), 0);

    // random ops on all three widths concurrently
    for (int n = 0; n < 1000; n++) begin
      ra2  = 16'($urandom_range(0, 3));     rb2  = 16'($urandom_range(0, 3));
      ra8  = 16'($urandom_range(0, 255));   rb8  = 16'($urandom_range(0, 255));
      ra16 = 16'($urandom_range(0, 65535)); rb16 = 16'($urandom_range(0, 65535));
      rc2 = 1'($urandom); rc8 = 1'($urandom); rc16 = 1'($urandom);
      if2.a  = ra2[1:0];  if2.b  = rb2[1:0];  if2.bin  = rc2; if2.start  = 1;
      if8.a  = ra8[7:0];  if8.b  = rb8[7:0];  if8.bin  = rc8; if8.start  = 1;
      if16.a = ra16;      if16.b = rb16;      if16.bin = rc16; if16.start = 1;
      @(posedge clk);
      #1 begin if2.start = 0; if8.start = 0; if16.start = 0; end
      got2 = 0; got8 = 0; got16 = 0;
      for (int c = 1; c <= 40 && !(got2 && got8 && got16); c++) begin
        @(negedge clk);
        if (if2.done && !got2) begin
          got2 = 1;
          chk("rand_w2", 32'({if2.bout, 16'(if2.diff)}), 32'(ref_sub(2, ra2, rb2, rc2)));
        end
        if (if8.done && !got8) begin
          got8 = 1;
          chk("rand_w8", 32'({if8.bout, 16'(if8.diff)}), 32'(ref_sub(8, ra8, rb8, rc8)));
        end
        if (if16.done && !got16) begin
          got16 = 1;
          chk("rand_w16", 32'({if16.bout, if16.diff}), 32'(ref_sub(16, ra16, rb16, rc16)));
        end
      end
      if (!(got2 && got8 && got16)) begin
        chk("rand_timeout", 32'({got2, got8, got16}), 32'b111);
        break;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
